alu_count_decode_unit: RTL and testbench
========================================

// Module: alu_count_decode_unit
// PURPOSE
// - Lab-board datapath slice with three independent sub-blocks sharing one clock/reset domain:
//   a 4-bit ALU with zero/overflow/carry flags, a 3-bit down-counter, and a 3-to-8 decoder with enable.
// - Sits under the board top level; switches/buttons drive inputs, LEDs/7-seg display outputs.
// PARAMETERS
// - CNT_RESET  3'd7  counter value loaded on reset (also the wrap-around target is fixed at 3'd7)
// PORTS
// - clk          in   1  system clock; all state updates on rising edge
// - resetn       in   1  reset, asynchronous, active-low
// - alu_fnselec  in   3  ALU operation select
// - alu_a        in   4  ALU operand A (two's complement)
// - alu_b        in   4  ALU operand B (two's complement)
// - alu_res      out  4  ALU result
// - alu_zero     out  1  1 when alu_res == 4'b0000
// - alu_overflow out  1  signed overflow (add/sub only)
// - alu_carry    out  1  carry-out (add/sub only)
// - cnt_en       in   1  down-counter enable
// - cnt_out      out  3  down-counter value
// - dec_x        in   3  decoder select
// - dec_en       in   1  decoder enable
// - dec_y        out  8  one-hot decoder output
// BEHAVIOUR
// - ALU (combinational, zero latency by default); carry/overflow = 0 for all non-arith ops:
//   000 add: {carry,res}=a+b; ovf=(a[3]==b[3])&&(res[3]!=a[3])
//   001 sub: {carry,res}=a+~b+1 (carry=1 means no borrow); ovf=(a[3]!=b[3])&&(res[3]!=a[3])
//   010 not: res=~a    011 and: res=a&b    100 or: res=a|b    101 xor: res=a^b
//   110 slt: res={3'b0, $signed(a)<$signed(b)}    111 eq: res={3'b0, a==b}
//   zero flag evaluated on final res for every op.
// - Counter: resetn low -> cnt_out=CNT_RESET immediately (async). Each rising clk with cnt_en=1:
//   cnt_out decrements by 1; 3'd0 wraps to 3'd7. cnt_en=0 holds value. Reset dominates cnt_en.
//   Reset asserted mid-count discards count; first decrement after release occurs on first clk edge
//   with resetn=1 and cnt_en=1.
// - Decoder (combinational): dec_en=1 -> dec_y = 8'b1 << dec_x; dec_en=0 -> dec_y = 8'h00.
// - Reset values: cnt_out=CNT_RESET; ALU and decoder outputs purely follow inputs (no reset state)
//   unless ALU_REG_OUT_EN defined.
// - No X propagation: every case/op select fully decoded, default branch drives res=0, flags=0.
// CONFIGURATION
// - ALU_REG_OUT_EN defined: alu_res/alu_zero/alu_overflow/alu_carry registered on rising clk
//   (1-cycle latency), async-cleared to 0 while resetn=0.
// - ALU_REG_OUT_EN undefined: ALU outputs combinational, same-cycle response; counter/decoder unaffected.
// TESTING
// - add 0111+0001 -> res=1000 ovf=1 carry=0 zero=0; add 1111+0001 -> res=0000 carry=1 zero=1 ovf=0
// - sub 1000-0001 -> res=0111 ovf=1 carry=1; sub 0011-0011 -> res=0000 zero=1 carry=1 ovf=0
// - slt a=1110 b=0001 -> 0001; eq a=b=1010 -> 0001; not a=0101 -> 1010; xor 1100^1010 -> 0110
// - resetn=0 then release, cnt_en=1 for 9 clks -> 7,6,5,4,3,2,1,0,7,6; cnt_en=0 -> value holds
// - resetn pulsed low between edges at cnt_out=3 -> cnt_out=7 immediately, without a clk edge
// - dec_en=1 dec_x=5 -> 8'b0010_0000; dec_x=0 -> 8'h01; dec_en=0 any dec_x -> 8'h00

Source files
------------

// File: rtl/alu_count_decode_unit_if.sv
// Bus bundle for the lab-board datapath slice: ALU, down-counter and decoder signals.
// The board top drives the master side; alu_count_decode_unit sits on the slave side.
interface alu_count_decode_unit_if;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       cnt_en;
  logic [2:0] cnt_out;
  logic [2:0] dec_x;
  logic       dec_en;
  logic [7:0] dec_y;

  modport master (
    output alu_fnselec, alu_a, alu_b, cnt_en, dec_x, dec_en,
    input  alu_res, alu_zero, alu_overflow, alu_carry, cnt_out, dec_y
  );

  modport slave (
    input  alu_fnselec, alu_a, alu_b, cnt_en, dec_x, dec_en,
    output alu_res, alu_zero, alu_overflow, alu_carry, cnt_out, dec_y
  );
endinterface

// File: rtl/alu_count_decode_unit.sv
// 4-bit ALU with flags, 3-bit wrapping down-counter and 3-to-8 decoder.
// Define ALU_REG_OUT_EN to register the ALU outputs (1-cycle latency, async-cleared).
module alu_count_decode_unit #(
  parameter logic [2:0] CNT_RESET = 3'd7
) (
  input logic                     clk,
  input logic                     resetn,
  alu_count_decode_unit_if.slave  bus
);

  localparam int unsigned ALU_W = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEC_W = 8;

  logic [ALU_W:0]   sum;
  logic [ALU_W-1:0] res_c;
  logic             zero_c;
  logic             ovf_c;
  logic             carry_c;
  logic [CNT_W-1:0] cnt;

  // ALU: every select decoded, flags only meaningful for add/sub
  always_comb begin
    sum     = '0;
    res_c   = '0;
    ovf_c   = 1'b0;
    carry_c = 1'b0;
    case (bus.alu_fnselec)
      3'b000: begin
        sum     = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        res_c   = sum[ALU_W-1:0];
        carry_c = sum[ALU_W];
        ovf_c   = (bus.alu_a[3] == bus.alu_b[3]) && (res_c[3] != bus.alu_a[3]);
      end
      3'b001: begin
        // carry=1 means no borrow
        sum     = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        res_c   = sum[ALU_W-1:0];
        carry_c = sum[ALU_W];
        ovf_c   = (bus.alu_a[3] != bus.alu_b[3]) && (res_c[3] != bus.alu_a[3]);
      end
      3'b010:  res_c = ~bus.alu_a;
      3'b011:  res_c = bus.alu_a & bus.alu_b;
      3'b100:  res_c = bus.alu_a | bus.alu_b;
      3'b101:  res_c = bus.alu_a ^ bus.alu_b;
      3'b110:  res_c = {3'b000, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      3'b111:  res_c = {3'b000, (bus.alu_a == bus.alu_b)};
      default: res_c = '0;
    endcase
    zero_c = (res_c == 4'b0000);
  end

`ifdef ALU_REG_OUT_EN
  logic [ALU_W-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             carry_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      res_q   <= res_c;
      zero_q  <= zero_c;
      ovf_q   <= ovf_c;
      carry_q <= carry_c;
    end
  end

  assign bus.alu_res      = res_q;
  assign bus.alu_zero     = zero_q;
  assign bus.alu_overflow = ovf_q;
  assign bus.alu_carry    = carry_q;
`else
  assign bus.alu_res      = res_c;
  assign bus.alu_zero     = zero_c;
  assign bus.alu_overflow = ovf_c;
  assign bus.alu_carry    = carry_c;
`endif

  // Down-counter: wraps 0 -> 7 regardless of the reset load value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= CNT_RESET;
    end else if (bus.cnt_en) begin
      cnt <= (cnt == 3'd0) ? 3'd7 : cnt - 3'd1;
    end
  end

  assign bus.cnt_out = cnt;
  assign bus.dec_y   = bus.dec_en ? (DEC_W'(1) << bus.dec_x) : 8'h00;

endmodule

// File: tb/tb_alu_count_decode_unit.sv
// Directed, table-driven bench for alu_count_decode_unit: ALU vectors, decoder
// vectors, and hand-written counter/reset sequences.
module tb_alu_count_decode_unit;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;

  alu_count_decode_unit_if bus ();

  alu_count_decode_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       zero;
    logic       ovf;
    logic       carry;
  } alu_vec_t;

  typedef struct {
    logic       en;
    logic [2:0] x;
    logic [7:0] y;
  } dec_vec_t;

  alu_vec_t alu_tab[15];
  dec_vec_t dec_tab[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //               fn      a        b        res     z     o     c
    alu_tab[0]  = '{3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0};
    alu_tab[1]  = '{3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
    alu_tab[2]  = '{3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1};
    alu_tab[3]  = '{3'b001, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1};
    alu_tab[4]  = '{3'b110, 4'b1110, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0};
    alu_tab[5]  = '{3'b111, 4'b1010, 4'b1010, 4'b0001, 1'b0, 1'b0, 1'b0};
    alu_tab[6]  = '{3'b010, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0};
    alu_tab[7]  = '{3'b101, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
    alu_tab[8]  = '{3'b011, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
    alu_tab[9]  = '{3'b100, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
    alu_tab[10] = '{3'b110, 4'b0001, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0};
    alu_tab[11] = '{3'b111, 4'b1010, 4'b1011, 4'b0000, 1'b1, 1'b0, 1'b0};
    alu_tab[12] = '{3'b001, 4'b0001, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0};
    alu_tab[13] = '{3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b1, 1'b0};
    alu_tab[14] = '{3'b001, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0};

    dec_tab[0] = '{1'b1, 3'd5, 8'b0010_0000};
    dec_tab[1] = '{1'b1, 3'd0, 8'h01};
    dec_tab[2] = '{1'b1, 3'd7, 8'h80};
    dec_tab[3] = '{1'b1, 3'd3, 8'h08};
    dec_tab[4] = '{1'b0, 3'd5, 8'h00};
    dec_tab[5] = '{1'b0, 3'd0, 8'h00};
    dec_tab[6] = '{1'b0, 3'd7, 8'h00};

    resetn          = 1'b0;
    bus.alu_fnselec = 3'b000;
    bus.alu_a       = 4'd0;
    bus.alu_b       = 4'd0;
    bus.cnt_en      = 1'b0;
    bus.dec_x       = 3'd0;
    bus.dec_en      = 1'b0;

    // reset dominates cnt_en across a clock edge
    bus.cnt_en = 1'b1;
    @(posedge clk); #1;
    chk("cnt_reset_hold", 32'(bus.cnt_out), 32'd7);
    bus.cnt_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("cnt_after_release_en0", 32'(bus.cnt_out), 32'd7);

    // ALU vectors: drive on negedge, sample after the next rising edge
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.alu_fnselec = alu_tab[i].fn;
      bus.alu_a       = alu_tab[i].a;
      bus.alu_b       = alu_tab[i].b;
      @(posedge clk); #1;
      chk($sformatf("alu_res[%0d]", i),   32'(bus.alu_res),      32'(alu_tab[i].res));
      chk($sformatf("alu_zero[%0d]", i),  32'(bus.alu_zero),     32'(alu_tab[i].zero));
      chk($sformatf("alu_ovf[%0d]", i),   32'(bus.alu_overflow), 32'(alu_tab[i].ovf));
      chk($sformatf("alu_carry[%0d]", i), 32'(bus.alu_carry),    32'(alu_tab[i].carry));
    end

    for (int i = 0; i < 7; i++) begin
      bus.dec_en = dec_tab[i].en;
      bus.dec_x  = dec_tab[i].x;
      #1;
      chk($sformatf("dec_y[%0d]", i), 32'(bus.dec_y), 32'(dec_tab[i].y));
    end

    // counter was held at 7 throughout; now 9 enabled edges
    @(negedge clk);
    bus.cnt_en = 1'b1;
    begin
      logic [2:0] exp_seq [9];
      exp_seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        chk($sformatf("cnt_seq[%0d]", i), 32'(bus.cnt_out), 32'(exp_seq[i]));
      end
    end

    // disable: value holds
    @(negedge clk);
    bus.cnt_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_hold", 32'(bus.cnt_out), 32'd6);

    // count down to 3, then async reset between edges
    @(negedge clk);
    bus.cnt_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_at_3", 32'(bus.cnt_out), 32'd3);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("cnt_async_reset", 32'(bus.cnt_out), 32'd7);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("cnt_first_after_reset", 32'(bus.cnt_out), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global guard so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
